// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: word-wide variable-latency memory port.
//   mem_req   master->slave  request, held until acknowledged
//   mem_we    master->slave  write strobe
//   mem_addr  master->slave  word address
//   mem_be    master->slave  byte enables, bit i selects lane i
//   mem_wdata master->slave  lane-replicated store data
//   mem_rdata slave->master  read data, valid with mem_ack
//   mem_ack   slave->master  acknowledge
interface mem_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata, input mem_rdata, mem_ack);
    modport slave  (input mem_req, mem_we, mem_addr, mem_be, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle load/store controller feeding the memory data register.
//   clk, rst_n       clock, asynchronous active-low reset
//   i_req            access request, sampled only in IDLE
//   i_we             1 = store, 0 = load
//   i_size           00 byte, 01 half, 10 word, 11 reserved
//   i_sign_ext       load extension select
//   i_addr, i_wdata  byte address, right-justified store data
//   o_busy           state is not IDLE
//   o_done           one-cycle completion pulse
//   o_rdata          aligned, extended load result
//   o_misalign       with done: misaligned access or reserved size
//   o_bus_err        with done: memory timeout
//   bus              memory port (master side)
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic        i_sign_ext,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_misalign,
    output logic        o_bus_err,
    mem_access_unit_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_wait;
    logic        r_we, r_sx;
    logic [1:0]  r_size, r_alo;
    logic        r_busy, r_done, r_misalign, r_bus_err, r_mem_req, r_mem_we;
    logic [31:0] r_rdata, r_mem_addr, r_mem_wdata;
    logic [3:0]  r_mem_be;
    logic        w_start, w_mis, w_ack, w_tmo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load;
    logic [15:0] w_half;
    logic [7:0]  w_byte;

    always_comb begin
        w_start = (r_state == S_IDLE) && i_req;
        w_mis   = (i_size == 2'b11) || (i_size == 2'b01 && i_addr[0]) || (i_size == 2'b10 && |i_addr[1:0]);
        w_be    = i_size == 2'b00 ? 4'b0001 << i_addr[1:0] :
                  i_size == 2'b01 ? (i_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        w_wdata = i_size == 2'b00 ? {4{i_wdata[7:0]}} :
                  i_size == 2'b01 ? {2{i_wdata[15:0]}} : i_wdata;
        w_ack   = (r_state == S_ACCESS) && bus.mem_ack;
        // Counter has already seen TIMEOUT-1 unacknowledged cycles: this is the last one.
        w_tmo   = (r_state == S_ACCESS) && !bus.mem_ack && (r_wait == 8'(TIMEOUT - 1));
        w_half  = r_alo[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        w_byte  = r_alo[0] ? w_half[15:8] : w_half[7:0];
        w_load  = r_size == 2'b00 ? {{24{r_sx & w_byte[7]}}, w_byte} :
                  r_size == 2'b01 ? {{16{r_sx & w_half[15]}}, w_half} : bus.mem_rdata;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   w_state_nxt = i_req ? (w_mis ? S_DONE : S_ACCESS) : S_IDLE;
            S_ACCESS: w_state_nxt = (w_ack || w_tmo) ? S_DONE : S_ACCESS;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wait      <= '0;
            r_we        <= 1'b0;
            r_sx        <= 1'b0;
            r_size      <= '0;
            r_alo       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_misalign  <= 1'b0;
            r_bus_err   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= w_state_nxt != S_IDLE;
            r_done     <= w_state_nxt == S_DONE;
            r_mem_req  <= w_state_nxt == S_ACCESS;
            r_mem_we   <= (w_state_nxt == S_ACCESS) && (w_start ? i_we : r_we);
            r_misalign <= w_start && w_mis;
            r_bus_err  <= w_tmo;
            r_wait     <= (r_state == S_ACCESS && !bus.mem_ack) ? r_wait + 8'd1 : 8'd0;
            if (w_start) begin
                r_we        <= i_we;
                r_sx        <= i_sign_ext;
                r_size      <= i_size;
                r_alo       <= i_addr[1:0];
                r_mem_addr  <= {i_addr[31:2], 2'b00};
                r_mem_be    <= w_be;
                r_mem_wdata <= w_wdata;
            end
            if (w_ack && !r_we)
                r_rdata <= w_load;
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_rdata       = r_rdata;
    assign o_misalign    = r_misalign;
    assign o_bus_err     = r_bus_err;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit (TIMEOUT=4).
module tb_mem_access_unit;
    logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0, sign_ext = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0, wdata = '0;
    logic        busy, done, misalign, bus_err;
    logic [31:0] rdata;
    int          n_pass = 0, n_tot = 0;

    mem_access_unit_if bus();

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .i_req(req), .i_we(we), .i_size(size),
        .i_sign_ext(sign_ext), .i_addr(addr), .i_wdata(wdata),
        .o_busy(busy), .o_done(done), .o_rdata(rdata),
        .o_misalign(misalign), .o_bus_err(bus_err), .bus(bus)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [1:0] s, input logic sx, input logic [31:0] a, input logic [31:0] d);
        we = w; size = s; sign_ext = sx; addr = a; wdata = d; req = 1'b1;
        step();
        req = 1'b0;
    endtask

    task automatic test_reset;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        #1;
        n_tot++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b want=0", busy); else n_pass++;
        n_tot++; if (done !== 1'b0) $display("FAIL rst_done got=%b want=0", done); else n_pass++;
        n_tot++; if (misalign !== 1'b0) $display("FAIL rst_misalign got=%b want=0", misalign); else n_pass++;
        n_tot++; if (bus_err !== 1'b0) $display("FAIL rst_bus_err got=%b want=0", bus_err); else n_pass++;
        n_tot++; if (rdata !== 32'h0) $display("FAIL rst_rdata got=%h want=0", rdata); else n_pass++;
        n_tot++; if (bus.mem_req !== 1'b0) $display("FAIL rst_mem_req got=%b want=0", bus.mem_req); else n_pass++;
        n_tot++; if (bus.mem_we !== 1'b0) $display("FAIL rst_mem_we got=%b want=0", bus.mem_we); else n_pass++;
        n_tot++; if (bus.mem_addr !== 32'h0) $display("FAIL rst_mem_addr got=%h want=0", bus.mem_addr); else n_pass++;
        n_tot++; if (bus.mem_be !== 4'h0) $display("FAIL rst_mem_be got=%b want=0", bus.mem_be); else n_pass++;
        n_tot++; if (bus.mem_wdata !== 32'h0) $display("FAIL rst_mem_wdata got=%h want=0", bus.mem_wdata); else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
    endtask

    task automatic test_word_load;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        n_tot++; if (bus.mem_req !== 1'b1) $display("FAIL wl_mem_req got=%b want=1", bus.mem_req); else n_pass++;
        n_tot++; if (bus.mem_we !== 1'b0) $display("FAIL wl_mem_we got=%b want=0", bus.mem_we); else n_pass++;
        n_tot++; if (bus.mem_be !== 4'b1111) $display("FAIL wl_mem_be got=%b want=1111", bus.mem_be); else n_pass++;
        n_tot++; if (bus.mem_addr !== 32'h10) $display("FAIL wl_mem_addr got=%h want=10", bus.mem_addr); else n_pass++;
        n_tot++; if (done !== 1'b0) $display("FAIL wl_done_early got=%b want=0", done); else n_pass++;
        step();
        n_tot++; if (done !== 1'b1) $display("FAIL wl_done got=%b want=1", done); else n_pass++;
        n_tot++; if (rdata !== 32'hDEADBEEF) $display("FAIL wl_rdata got=%h want=deadbeef", rdata); else n_pass++;
        step();
        n_tot++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL wl_idle done=%b busy=%b want=0,0", done, busy); else n_pass++;
    endtask

    task automatic test_byte_loads;
        logic [31:0] a_t [4] = '{32'h13, 32'h11, 32'h12, 32'h10};
        logic [1:0]  s_t [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        x_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0]  b_t [4] = '{4'b1000, 4'b0010, 4'b1100, 4'b0011};
        logic [31:0] r_t [4] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01};
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h80FF7F01;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, s_t[i], x_t[i], a_t[i], 32'h0);
            n_tot++; if (bus.mem_be !== b_t[i]) $display("FAIL ld%0d_be got=%b want=%b", i, bus.mem_be, b_t[i]); else n_pass++;
            step();
            n_tot++; if (done !== 1'b1 || rdata !== r_t[i]) $display("FAIL ld%0d_rdata done=%b got=%h want=%h", i, done, rdata, r_t[i]); else n_pass++;
            step();
        end
    endtask

    task automatic test_store;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h99999999;
        issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234ABCD);
        n_tot++; if (bus.mem_we !== 1'b1) $display("FAIL sh_mem_we got=%b want=1", bus.mem_we); else n_pass++;
        n_tot++; if (bus.mem_wdata !== 32'hABCDABCD) $display("FAIL sh_wdata got=%h want=abcdabcd", bus.mem_wdata); else n_pass++;
        n_tot++; if (bus.mem_be !== 4'b1100) $display("FAIL sh_be got=%b want=1100", bus.mem_be); else n_pass++;
        n_tot++; if (bus.mem_addr !== 32'h20) $display("FAIL sh_addr got=%h want=20", bus.mem_addr); else n_pass++;
        step();
        n_tot++; if (done !== 1'b1 || rdata !== 32'h00007F01) $display("FAIL sh_rdata done=%b got=%h want=00007f01", done, rdata); else n_pass++;
        step();
        issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000005A);
        n_tot++; if (bus.mem_wdata !== 32'h5A5A5A5A || bus.mem_be !== 4'b0010) $display("FAIL sb_fmt wdata=%h be=%b want=5a5a5a5a,0010", bus.mem_wdata, bus.mem_be); else n_pass++;
        step();
        step();
        n_tot++; if (bus.mem_we !== 1'b0) $display("FAIL sb_we_idle got=%b want=0", bus.mem_we); else n_pass++;
    endtask

    task automatic test_misalign;
        logic [1:0]  s_t [3] = '{2'b10, 2'b11, 2'b01};
        logic [31:0] a_t [3] = '{32'h06, 32'h00, 32'h01};
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, s_t[i], 1'b0, a_t[i], 32'h0);
            n_tot++; if (done !== 1'b1 || misalign !== 1'b1) $display("FAIL mis%0d_flag done=%b misalign=%b want=1,1", i, done, misalign); else n_pass++;
            n_tot++; if (bus.mem_req !== 1'b0 || bus_err !== 1'b0) $display("FAIL mis%0d_noreq mem_req=%b bus_err=%b want=0,0", i, bus.mem_req, bus_err); else n_pass++;
            step();
            n_tot++; if (done !== 1'b0 || misalign !== 1'b0 || busy !== 1'b0) $display("FAIL mis%0d_clear done=%b misalign=%b busy=%b want=0", i, done, misalign, busy); else n_pass++;
        end
        n_tot++; if (rdata !== 32'h00007F01) $display("FAIL mis_rdata got=%h want=00007f01", rdata); else n_pass++;
    endtask

    task automatic test_wait_states;
        int lat = 0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0BADF00D;
        issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
        for (int k = 1; k <= 10; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (k == 3) bus.mem_ack = 1'b1;
            step();
        end
        n_tot++; if (lat != 4) $display("FAIL wait2_latency got=%0d want=4", lat); else n_pass++;
        n_tot++; if (rdata !== 32'h0BADF00D) $display("FAIL wait2_rdata got=%h want=0badf00d", rdata); else n_pass++;
        bus.mem_ack = 1'b0;
        step();
    endtask

    task automatic test_timeout;
        int lat = 0, nreq = 0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h55555555;
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        for (int k = 1; k <= 20; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (bus.mem_req) nreq++;
            step();
        end
        n_tot++; if (lat != 5) $display("FAIL tmo_latency got=%0d want=5", lat); else n_pass++;
        n_tot++; if (nreq != 4) $display("FAIL tmo_req_cycles got=%0d want=4", nreq); else n_pass++;
        n_tot++; if (bus_err !== 1'b1 || misalign !== 1'b0) $display("FAIL tmo_flags bus_err=%b misalign=%b want=1,0", bus_err, misalign); else n_pass++;
        n_tot++; if (rdata !== 32'h0BADF00D) $display("FAIL tmo_rdata got=%h want=0badf00d", rdata); else n_pass++;
        step();
        n_tot++; if (bus_err !== 1'b0 || busy !== 1'b0) $display("FAIL tmo_clear bus_err=%b busy=%b want=0,0", bus_err, busy); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [5:0] pat = 6'b010010;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hA5A5A5A5;
        we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h60; req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            n_tot++; if (done !== pat[k-1]) $display("FAIL b2b_done%0d got=%b want=%b", k, done, pat[k-1]); else n_pass++;
            if (k == 2) begin
                n_tot++; if (rdata !== 32'hA5A5A5A5) $display("FAIL b2b_rdata1 got=%h want=a5a5a5a5", rdata); else n_pass++;
            end
            if (k == 3) bus.mem_rdata = 32'h11223344;
            if (k == 4) req = 1'b0;
            if (k == 5) begin
                n_tot++; if (rdata !== 32'h11223344) $display("FAIL b2b_rdata2 got=%h want=11223344", rdata); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid;
        bus.mem_ack = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 32'h50, 32'h0);
        step();
        n_tot++; if (bus.mem_req !== 1'b1) $display("FAIL rm_pre_req got=%b want=1", bus.mem_req); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_tot++; if (bus.mem_req !== 1'b0 || busy !== 1'b0) $display("FAIL rm_async mem_req=%b busy=%b want=0,0", bus.mem_req, busy); else n_pass++;
        n_tot++; if (rdata !== 32'h0) $display("FAIL rm_rdata got=%h want=0", rdata); else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        bus.mem_rdata = 32'hCAFEF00D; bus.mem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_tot++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL rm_late_ack%0d done=%b busy=%b want=0,0", k, done, busy); else n_pass++;
        end
        issue(1'b0, 2'b10, 1'b0, 32'h54, 32'h0);
        step();
        n_tot++; if (done !== 1'b1 || rdata !== 32'hCAFEF00D) $display("FAIL rm_next done=%b rdata=%h want=1,cafef00d", done, rdata); else n_pass++;
        step();
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_loads();
        test_store();
        test_misalign();
        test_wait_states();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle memory access controller that sits directly upstream of the memory data register. It takes one load/store command per access from the multi-cycle control unit and drives a variable-latency word-wide memory port with byte enables and lane-replicated store data. Load data is aligned and sign- or zero-extended before it is presented to the memory data register, which latches it on the next clock. It also flags misaligned accesses and memory timeouts.

## Interface
- TIMEOUT, 16: cycles in ACCESS without mem_ack before the access is aborted with bus_err; legal range 1..255.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  aligned and extended load result; feeds the memory data register input.
- misalign  out  1  valid with done: the access was misaligned or the size was reserved.
- bus_err  out  1  valid with done: the access timed out.
- mem_req  out  1  memory request; held until acknowledged.
- mem_we  out  1  memory write strobe.
- mem_addr  out  32  word address, {addr[31:2], 2'b00}.
- mem_be  out  4  byte enables; bit i selects mem_wdata[8i+7:8i].
- mem_wdata  out  32  store data replicated across lanes.
- mem_rdata  in  32  memory read data; valid when mem_ack is high.
- mem_ack  in  1  memory acknowledge.

## Operation
- States: IDLE, ACCESS, DONE. All outputs are registered.
- In IDLE with req=1 at an edge:
  - capture we, size, sign_ext, addr[1:0] and the formatted store data/enables.
  - If the access is misaligned or the size is reserved, go to DONE with misalign=1; no memory cycle is issued.
  - Otherwise go to ACCESS.
- Misalignment rules:
  - halfword with addr[0]=1;
  - word with addr[1:0]≠00;
  - size=11 always.
- ACCESS:
  - mem_req=1 and mem_we=we; mem_addr, mem_be and mem_wdata are held stable.
  - On an edge with mem_ack=1, go to DONE; for loads, rdata is updated from mem_rdata at that edge.
  - A wait counter clears on entry and increments each ACCESS cycle without ack.
  - When the counter reaches TIMEOUT-1 with no ack, go to DONE with bus_err=1; rdata is unchanged.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE. req is ignored in DONE.
- Store formatting:
  - byte: mem_wdata={4{wdata[7:0]}}, mem_be=0001<<addr[1:0].
  - half: mem_wdata={2{wdata[15:0]}}, mem_be = addr[1] ? 1100 : 0011.
  - word: mem_wdata=wdata, mem_be=1111.
- Load formatting (little-endian):
  - byte: mem_rdata[8·a+7:8·a], where a=addr[1:0].
  - half: mem_rdata[16·addr[1]+15:16·addr[1]].
  - Extend to 32 bits per sign_ext.
  - On loads, mem_be reflects the accessed lanes.
- rdata holds its value between loads. Stores, misaligned accesses and timeouts never modify rdata.
- misalign and bus_err are high only in DONE; both are 0 otherwise.

## Timing
- Reset (async assert, deasserted synchronously by the system): state=IDLE, wait counter=0. All outputs are 0: busy, done, misalign, bus_err, rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata.
- Reset mid-access: mem_req drops immediately and the transaction is abandoned. A late mem_ack arriving in IDLE is ignored.
- Minimum latency, req edge to done high:
  - 2 cycles with zero-wait memory (ack in the first ACCESS cycle);
  - 1 cycle for a misaligned access.
- With N wait cycles, done is high 2+N cycles after the req edge.
- Timeout: done is high TIMEOUT+1 cycles after the req edge.
- mem_ack outside ACCESS is ignored. mem_rdata is sampled only at the ack edge.
- Back-to-back: req held high through DONE is re-sampled in IDLE, giving one access per 3 cycles at zero wait.
- rdata is stable from the edge that raises done until the next completed load. The memory data register captures it on the edge after done or any later edge.

## Test plan
- Word load: addr=0x10, mem_rdata=0xDEADBEEF, ack on first ACCESS cycle -> mem_be=1111, mem_addr=0x10, done 2 cycles after req, rdata=0xDEADBEEF.
- Byte loads from word 0x80FF7F01:
  - addr[1:0]=3, sign_ext=1 -> rdata=0xFFFFFF80;
  - addr[1:0]=1, sign_ext=0 -> rdata=0x0000007F.
- Half store: wdata=0x1234ABCD, addr=0x22 -> mem_wdata=0xABCDABCD, mem_be=1100, mem_we=1; rdata unchanged.
- Misaligned word load at 0x06 -> mem_req never asserts, done+misalign 1 cycle after req. size=11 gives the same response.
- Timeout with TIMEOUT=4, ack never arrives -> mem_req high 4 cycles, done+bus_err, rdata keeps its prior value.
- Assert rst_n low in the 2nd ACCESS cycle -> mem_req and busy go to 0 immediately. An ack after release produces no done. The next access completes normally.
